// File: rtl/clock_pkg.sv
// Shared constants for the clock time-set path: default timing and FSM encoding.
package clock_pkg;

    localparam int CLK_HZ    = 100_000_000;
    localparam int DEB_CYC   = 1_000_000;
    localparam int DELAY_CYC = 50_000_000;
    localparam int RATE_CYC  = 12_500_000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FIRST   = 3'd1;
    localparam logic [2:0] ST_DELAY   = 3'd2;
    localparam logic [2:0] ST_REPEAT  = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic SEL_HOUR = 1'b0;
    localparam logic SEL_MIN  = 1'b1;

    // Timer must hold the larger reload value; never narrower than one bit.
    function automatic int timer_width(input int delay_cyc, input int rate_cyc);
        int m;
        m = (delay_cyc > rate_cyc) ? delay_cyc : rate_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button inputs and increment/setting outputs of the time-set controller.
interface time_set_controller_if;
    logic btn_hour;
    logic btn_min;
    logic inc_hour;
    logic inc_min;
    logic setting;

    modport master (output btn_hour, output btn_min,
                    input  inc_hour, input  inc_min, input setting);
    modport slave  (input  btn_hour, input  btn_min,
                    output inc_hour, output inc_min, output setting);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a level debouncer for one raw push button.
module btn_debounce #(
    parameter int DEB_CYC = clock_pkg::DEB_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive cycles the synchronized value differs from the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_p1 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync_p1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Hour/minute set-button controller: single step on press, auto-repeat while held.
module time_set_controller #(
    parameter int DEB_CYC   = clock_pkg::DEB_CYC,
    parameter int DELAY_CYC = clock_pkg::DELAY_CYC,
    parameter int RATE_CYC  = clock_pkg::RATE_CYC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    time_set_controller_if.slave        bus
);
    import clock_pkg::*;

    localparam int TW = timer_width(DELAY_CYC, RATE_CYC);
    localparam logic [TW-1:0] DELAY_LOAD = TW'(DELAY_CYC - 1);
    localparam logic [TW-1:0] RATE_LOAD  = TW'(RATE_CYC - 1);

    logic          deb_hour;
    logic          deb_min;
    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic          sel;
    logic          sel_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    logic          pulse_nx;
    logic          locked_lvl;
    logic          hour_pulse;
    logic          min_pulse;
    logic          setting_r;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.btn_hour),
        .level (deb_hour)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_min (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.btn_min),
        .level (deb_min)
    );

    // The timer counts from the cycle of each pulse, so the first reload happens on entry to FIRST.
    always_comb begin
        state_nx   = state;
        sel_nx     = sel;
        timer_nx   = timer;
        pulse_nx   = 1'b0;
        locked_lvl = (sel == SEL_HOUR) ? deb_hour : deb_min;
        case (state)
            ST_IDLE: begin
                if (deb_hour || deb_min) begin
                    state_nx = ST_FIRST;
                    sel_nx   = deb_hour ? SEL_HOUR : SEL_MIN;
                    timer_nx = DELAY_LOAD;
                    pulse_nx = 1'b1;
                end
            end
            ST_FIRST: begin
                state_nx = ST_DELAY;
                if (timer != '0) timer_nx = timer - TW'(1);
            end
            ST_DELAY, ST_REPEAT: begin
                if (!locked_lvl) begin
                    state_nx = ST_RELEASE;
                end else if (timer == '0) begin
                    state_nx = ST_REPEAT;
                    timer_nx = RATE_LOAD;
                    pulse_nx = 1'b1;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            ST_RELEASE: begin
                if (!deb_hour && !deb_min) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= SEL_HOUR;
            timer      <= '0;
            hour_pulse <= 1'b0;
            min_pulse  <= 1'b0;
            setting_r  <= 1'b0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            timer      <= timer_nx;
            hour_pulse <= pulse_nx && (sel_nx == SEL_HOUR);
            min_pulse  <= pulse_nx && (sel_nx == SEL_MIN);
            setting_r  <= (state_nx != ST_IDLE);
        end
    end

    assign bus.inc_hour = hour_pulse;
    assign bus.inc_min  = min_pulse;
    assign bus.setting  = setting_r;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: vector table, corner sequences and random stimulus vs. a behavioural model.
module tb_time_set_controller;

    localparam int DEB   = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 8;

    logic clk = 1'b0;
    logic rst_n;
    time_set_controller_if bus ();

    time_set_controller #(.DEB_CYC(DEB), .DELAY_CYC(DELAY), .RATE_CYC(RATE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Behavioural reference: raw sample history, run-length debounce, and a press/lock/schedule view.
    bit hq[$];
    bit mq[$];
    bit m_dh, m_dm;
    int lock;       // 0 none, 1 hour, 2 minute
    bit wait_rel;
    int t;
    int next_at;
    bit e_ih, e_im, e_set;

    function automatic bit qv(input bit q[$], input int k);
        return (k < q.size()) ? q[q.size()-1-k] : 1'b0;
    endfunction

    function automatic bit deb_next(input bit cur, input bit q[$]);
        bit v;
        v = qv(q, 2);
        for (int k = 3; k <= DEB + 1; k++)
            if (qv(q, k) != v) return cur;
        return v;
    endfunction

    task automatic model_reset();
        hq.delete(); mq.delete();
        m_dh = 0; m_dm = 0; lock = 0; wait_rel = 0;
        t = 0; next_at = 0; e_ih = 0; e_im = 0; e_set = 0;
    endtask

    task automatic model_edge(input bit h, input bit m);
        bit lvl;
        e_ih = 0; e_im = 0;
        if (lock == 0 && !wait_rel) begin
            if (m_dh || m_dm) begin
                lock    = m_dh ? 1 : 2;
                e_ih    = (lock == 1);
                e_im    = (lock == 2);
                next_at = t + DELAY;
            end
        end else if (lock != 0) begin
            lvl = (lock == 1) ? m_dh : m_dm;
            if (!lvl) begin
                lock = 0; wait_rel = 1;
            end else if (t == next_at) begin
                e_ih    = (lock == 1);
                e_im    = (lock == 2);
                next_at = t + RATE;
            end
        end else if (!m_dh && !m_dm) begin
            wait_rel = 0;
        end
        e_set = (lock != 0) || wait_rel;
        hq.push_back(h); mq.push_back(m);
        if (hq.size() > DEB + 3) begin void'(hq.pop_front()); void'(mq.pop_front()); end
        m_dh = deb_next(m_dh, hq);
        m_dm = deb_next(m_dm, mq);
        t++;
    endtask

    task automatic step(input bit h, input bit m);
        bus.btn_hour = h;
        bus.btn_min  = m;
        @(posedge clk);
        model_edge(h, m);
        #1;
        check("cyc_inc_hour", int'(bus.inc_hour), int'(e_ih));
        check("cyc_inc_min",  int'(bus.inc_min),  int'(e_im));
        check("cyc_setting",  int'(bus.setting),  int'(e_set));
        check("cyc_exclusive", int'(bus.inc_hour && bus.inc_min), 0);
    endtask

    task automatic do_reset(input bit h, input bit m);
        bus.btn_hour = h;
        bus.btn_min  = m;
        rst_n = 1'b0;
        #1;
        check("rst_inc_hour", int'(bus.inc_hour), 0);
        check("rst_inc_min",  int'(bus.inc_min),  0);
        check("rst_setting",  int'(bus.setting),  0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int h_on, h_off, m_on, m_off, m2_on, m2_off;
        int n_hour, n_min, f_hour, f_min;
        int set_seen;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n_h, n_m, f_h, f_m, seen, first;
        bit rh, rm, hv, mv;
        int hl, ml;

        tbl[0] = '{0, 0,  0,  3,  0,  0, 0, 0, -1, -1, 0};
        tbl[1] = '{0, 0,  0, 10,  0,  0, 0, 1, -1,  7, 1};
        tbl[2] = '{0, 60, 0,  0,  0,  0, 6, 0,  7, -1, 1};
        tbl[3] = '{0, 15, 0, 40,  0,  0, 1, 0,  7, -1, 1};
        tbl[4] = '{0, 15, 0, 30, 40, 50, 1, 1,  7, 47, 1};
        tbl[5] = '{0, 0,  5, 35,  0,  0, 0, 3, -1, 12, 1};
        tbl[6] = '{0, 10, 3, 13,  0,  0, 1, 0,  7, -1, 1};

        rst_n = 1'b0;
        bus.btn_hour = 1'b0;
        bus.btn_min  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_inc_hour", int'(bus.inc_hour), 0);
        check("init_inc_min",  int'(bus.inc_min),  0);
        check("init_setting",  int'(bus.setting),  0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_reset(1'b0, 1'b0);
            n_h = 0; n_m = 0; f_h = -1; f_m = -1; seen = 0;
            for (int k = 0; k < 100; k++) begin
                hv = (k >= tbl[i].h_on && k < tbl[i].h_off);
                mv = (k >= tbl[i].m_on && k < tbl[i].m_off) ||
                     (k >= tbl[i].m2_on && k < tbl[i].m2_off);
                step(hv, mv);
                if (bus.inc_hour) begin n_h++; if (f_h < 0) f_h = k + 1; end
                if (bus.inc_min)  begin n_m++; if (f_m < 0) f_m = k + 1; end
                if (bus.setting) seen = 1;
            end
            check($sformatf("v%0d_n_hour", i), n_h, tbl[i].n_hour);
            check($sformatf("v%0d_n_min", i), n_m, tbl[i].n_min);
            check($sformatf("v%0d_first_hour", i), f_h, tbl[i].f_hour);
            check($sformatf("v%0d_first_min", i), f_m, tbl[i].f_min);
            check($sformatf("v%0d_setting_seen", i), seen, tbl[i].set_seen);
            check($sformatf("v%0d_setting_end", i), int'(bus.setting), 0);
        end

        // Reset asserted while auto-repeating, button kept held through and after reset.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b1, 1'b0);
        check("rep_setting_before_rst", int'(bus.setting), 1);
        do_reset(1'b1, 1'b0);
        first = -1;
        for (int n = 1; n <= 30; n++) begin
            step(1'b1, 1'b0);
            if (bus.inc_hour && first < 0) first = n;
        end
        check("rst_mid_press_latency", first, DEB + 3);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0);

        // Bouncing minute button that settles high at step 20.
        do_reset(1'b0, 1'b0);
        n_m = 0; first = -1;
        for (int k = 0; k < 60; k++) begin
            mv = (k < 20) ? (((k / 2) % 2) == 0) : (k < 35);
            step(1'b0, mv);
            if (bus.inc_min) begin n_m++; if (first < 0) first = k; end
        end
        check("bounce_n_min", n_m, 1);
        check("bounce_pulse_step", first, 20 + DEB + 2);

        // Random hold/release patterns with occasional resets.
        do_reset(1'b0, 1'b0);
        rh = 0; rm = 0; hl = 0; ml = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hl == 0) begin rh = 1'($urandom_range(0, 1)); hl = $urandom_range(1, 45); end
            if (ml == 0) begin rm = 1'($urandom_range(0, 1)); ml = $urandom_range(1, 45); end
            hl--; ml--;
            if ($urandom_range(0, 599) == 0) do_reset(rh, rm);
            step(rh, rm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
